// File: rtl/wb_arb_pkg.sv
// Shared types and the round-robin pick for the Wishbone RAM-port arbiter.
package wb_arb_pkg;

  localparam int ARB_NMASTERS = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_e;

  // A lone requester always wins; on contention the master not served last wins.
  function automatic logic rr_pick(input logic [ARB_NMASTERS-1:0] req,
                                   input logic                    last);
    case (req)
      2'b01:   rr_pick = 1'b0;
      2'b10:   rr_pick = 1'b1;
      default: rr_pick = ~last;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with an ack watchdog.
// One transfer per grant; an IDLE cycle always separates transfers.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_ni,
  input  logic [2*(ADDR_WIDTH-2)-1:0]     m_wb_adr_i,
  input  logic [63:0]                     m_wb_dat_i,
  output logic [63:0]                     m_wb_dat_o,
  input  logic [1:0]                      m_wb_we_i,
  input  logic [7:0]                      m_wb_sel_i,
  input  logic [1:0]                      m_wb_stb_i,
  output logic [1:0]                      m_wb_ack_o,
  output logic [1:0]                      m_wb_err_o,
  output logic [ADDR_WIDTH-3:0]           s_wb_adr_o,
  output logic [31:0]                     s_wb_dat_o,
  input  logic [31:0]                     s_wb_dat_i,
  output logic                            s_wb_we_o,
  output logic [3:0]                      s_wb_sel_o,
  output logic                            s_wb_stb_o,
  input  logic                            s_wb_ack_i
);

  localparam int         AW    = ADDR_WIDTH - 2;
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_e state_q;
  logic       owner_q;
  logic       last_q;
  logic [7:0] tcnt_q;

  logic active;
  logic own_stb;
  logic tmo;

  // Outputs are forced low while reset is held, even before the edge lands.
  always_comb begin
    active     = wb_rst_ni && (state_q == ARB_ACTIVE);
    own_stb    = owner_q ? m_wb_stb_i[1] : m_wb_stb_i[0];
    tmo        = active && own_stb && !s_wb_ack_i && (tcnt_q == TLAST);
    s_wb_stb_o = active && own_stb;
    s_wb_we_o  = active && (owner_q ? m_wb_we_i[1] : m_wb_we_i[0]);
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    s_wb_sel_o = '0;
    if (active) begin
      s_wb_adr_o = owner_q ? m_wb_adr_i[2*AW-1:AW] : m_wb_adr_i[AW-1:0];
      s_wb_dat_o = owner_q ? m_wb_dat_i[63:32]     : m_wb_dat_i[31:0];
      s_wb_sel_o = owner_q ? m_wb_sel_i[7:4]       : m_wb_sel_i[3:0];
    end
    m_wb_ack_o = '0;
    m_wb_err_o = '0;
    if (active && s_wb_ack_i) m_wb_ack_o[owner_q] = 1'b1;
    if (tmo)                  m_wb_err_o[owner_q] = 1'b1;
  end

  assign m_wb_dat_o = {ARB_NMASTERS{s_wb_dat_i}};

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|m_wb_stb_i) begin
            state_q <= ARB_ACTIVE;
            owner_q <= rr_pick(m_wb_stb_i, last_q);
            tcnt_q  <= '0;
          end
        end
        ARB_ACTIVE: begin
          // Ack, master abort and watchdog expiry all end the transfer.
          if (s_wb_ack_i || !own_stb || (tcnt_q == TLAST)) begin
            state_q <= ARB_IDLE;
            last_q  <= owner_q;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2 with a programmable-latency RAM stub.
module tb_wb_arbiter2;

  localparam int AW = 14;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2*AW-1:0]   m_adr = '0;
  logic [63:0]       m_dat = '0;
  logic [63:0]       m_rdat;
  logic [1:0]        m_we = '0;
  logic [7:0]        m_sel = '0;
  logic [1:0]        m_stb = '0;
  logic [1:0]        m_ack;
  logic [1:0]        m_err;
  logic [AW-1:0]     s_adr;
  logic [31:0]       s_dat;
  logic [31:0]       sdat = '0;
  logic              s_we;
  logic [3:0]        s_sel;
  logic              s_stb;
  logic              sack = 1'b0;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int dly = 1;
  int scnt = 0;
  int t0;
  logic [31:0] mem [256];

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    bit          chk_dat;
    logic [31:0] dat;
    int          idx;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   ack_times[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_arbiter2 #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_wb_adr_i(m_adr), .m_wb_dat_i(m_dat), .m_wb_dat_o(m_rdat),
    .m_wb_we_i(m_we), .m_wb_sel_i(m_sel), .m_wb_stb_i(m_stb),
    .m_wb_ack_o(m_ack), .m_wb_err_o(m_err),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat), .s_wb_dat_i(sdat),
    .s_wb_we_o(s_we), .s_wb_sel_o(s_sel), .s_wb_stb_o(s_stb),
    .s_wb_ack_i(sack)
  );

  // RAM stub: acks dly cycles after strobe rises (dly==0 never acks).
  always @(posedge clk) begin
    if (s_stb && !sack) begin
      if (s_we)
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) mem[s_adr[7:0]][8*b +: 8] <= s_dat[8*b +: 8];
      sdat <= mem[s_adr[7:0]];
      sack <= (dly != 0) && (scnt == dly - 1);
      scnt <= scnt + 1;
    end else begin
      sack <= 1'b0;
      scnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_stb[i]            = stb;
    m_we[i]             = we;
    m_adr[i*AW +: AW]   = adr;
    m_dat[i*32 +: 32]   = dat;
    m_sel[i*4 +: 4]     = sel;
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [1:0] e,
                          input bit cd, input logic [31:0] d, input int idx);
    exp_t x;
    x.ack = a; x.err = e; x.chk_dat = cd; x.dat = d; x.idx = idx;
    sbq.push_back(x);
  endtask

  task automatic wait_resp(input int maxc);
    bit got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (m_ack != 2'b00 || m_err != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("wait_resp_timeout", 64'd0, 64'd1);
  endtask

  // Response monitor: every ack/err must match the head of the scoreboard.
  always @(negedge clk) begin
    if (m_ack != 2'b00 || m_err != 2'b00) begin
      ack_times.push_back(cyc);
      chk("ack_onehot", {63'd0, m_ack == 2'b11}, 64'd0);
      if (sbq.size() == 0) begin
        chk("unexp_resp", {60'd0, m_ack, m_err}, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_ackerr", {60'd0, m_ack, m_err}, {60'd0, mon_e.ack, mon_e.err});
        if (mon_e.chk_dat)
          chk("resp_dat", mon_e.idx == 1 ? m_rdat[63:32] : m_rdat[31:0], mon_e.dat);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = 32'h12345678;
    mem[8'h30] = 32'h11223344;

    // Reset state, including requests presented while reset is held
    tick; tick;
    @(negedge clk);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_dat_pass", m_rdat, {2{sdat}});
    tick;
    set_m(0, 1, 1, 14'h010, 32'h0, 4'hF);
    set_m(1, 1, 1, 14'h020, 32'h0, 4'hF);
    @(negedge clk);
    chk("rst_req_s_stb", s_stb, 0);
    chk("rst_req_s_we", s_we, 0);
    tick;
    m_stb = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_stb", s_stb, 0);
    chk("idle_s_adr", s_adr, 0);

    // Master 0 write, fixed latency
    tick;
    set_m(0, 1, 1, 14'h010, 32'hDEADBEEF, 4'hF);
    t0 = cyc;
    push_exp(2'b01, 2'b00, 0, 32'h0, 0);
    @(negedge clk); chk("t1_idle_stb", s_stb, 0);
    @(negedge clk);
    chk("t1_s_stb", s_stb, 1);
    chk("t1_s_adr", s_adr, 14'h010);
    chk("t1_s_dat", s_dat, 32'hDEADBEEF);
    chk("t1_s_we",  s_we, 1);
    chk("t1_s_sel", s_sel, 4'hF);
    @(negedge clk);
    chk("t1_ack", m_ack, 2'b01);
    chk("t1_lat", cyc - t0, 2);
    tick; m_stb = 2'b00;

    // Read back, then a master 1 partial-byte write and readback
    tick; set_m(0, 1, 0, 14'h010, 32'h0, 4'hF);
    push_exp(2'b01, 2'b00, 1, 32'hDEADBEEF, 0);
    wait_resp(10);
    tick; m_stb = 2'b00;
    tick; set_m(1, 1, 1, 14'h030, 32'hA5A5A5A5, 4'b0011);
    push_exp(2'b10, 2'b00, 0, 32'h0, 1);
    wait_resp(10);
    tick; m_stb = 2'b00;
    tick; set_m(1, 1, 0, 14'h030, 32'h0, 4'hF);
    push_exp(2'b10, 2'b00, 1, 32'h1122A5A5, 1);
    wait_resp(10);
    tick; m_stb = 2'b00;

    // Both masters continuous from reset: 0,1,0,1 every 3 cycles
    tick; rst_n = 1'b0;
    set_m(0, 1, 0, 14'h010, 32'h0, 4'hF);
    set_m(1, 1, 0, 14'h020, 32'h0, 4'hF);
    tick; rst_n = 1'b1;
    ack_times.delete();
    push_exp(2'b01, 2'b00, 1, 32'hDEADBEEF, 0);
    push_exp(2'b10, 2'b00, 1, 32'h12345678, 1);
    push_exp(2'b01, 2'b00, 1, 32'hDEADBEEF, 0);
    push_exp(2'b10, 2'b00, 1, 32'h12345678, 1);
    for (int k = 0; k < 4; k++) wait_resp(10);
    tick; m_stb = 2'b00;
    chk("t2_nacks", ack_times.size(), 4);
    for (int i = 1; i < ack_times.size(); i++)
      chk("t2_spacing", ack_times[i] - ack_times[i-1], 3);

    // Watchdog: no ack, err on 4th ACTIVE cycle, then other master wins
    tick; dly = 0;
    set_m(0, 1, 0, 14'h010, 32'h0, 4'hF);
    set_m(1, 1, 0, 14'h020, 32'h0, 4'hF);
    t0 = cyc;
    push_exp(2'b00, 2'b01, 0, 32'h0, 0);
    push_exp(2'b10, 2'b00, 1, 32'h12345678, 1);
    @(negedge clk);
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      chk("t3_s_stb", s_stb, 1);
      chk("t3_err_early", m_err, 0);
    end
    @(negedge clk);
    chk("t3_err", m_err, 2'b01);
    chk("t3_err_ack", m_ack, 0);
    chk("t3_err_cyc", cyc - t0, TO);
    tick; dly = 1;
    @(negedge clk); chk("t3_idle_after", s_stb, 0);
    @(negedge clk); chk("t3_regrant_adr", s_adr, 14'h020);
    wait_resp(10);
    tick; m_stb = 2'b00;

    // Ack landing on the watchdog cycle wins
    tick; dly = 3;
    set_m(0, 1, 0, 14'h010, 32'h0, 4'hF);
    t0 = cyc;
    push_exp(2'b01, 2'b00, 1, 32'hDEADBEEF, 0);
    wait_resp(10);
    chk("t4_ack_cyc", cyc - t0, TO);
    tick; m_stb = 2'b00; dly = 1;

    // Master 1 aborts in ACTIVE; pending master 0 granted after one IDLE
    tick; set_m(1, 1, 0, 14'h020, 32'h0, 4'hF);
    push_exp(2'b01, 2'b00, 1, 32'hDEADBEEF, 0);
    @(negedge clk);
    tick;
    m_stb[1] = 1'b0;
    set_m(0, 1, 0, 14'h010, 32'h0, 4'hF);
    @(negedge clk);
    chk("t5_abort_stb", s_stb, 0);
    chk("t5_abort_ack", m_ack, 0);
    @(negedge clk); chk("t5_idle_stb", s_stb, 0);
    @(negedge clk);
    chk("t5_m0_grant", s_stb, 1);
    chk("t5_m0_adr", s_adr, 14'h010);
    wait_resp(10);
    tick; m_stb = 2'b00;

    // Reset during ACTIVE drops the transfer; master 0 wins afterwards
    tick; dly = 0;
    set_m(0, 1, 0, 14'h010, 32'h0, 4'hF);
    @(negedge clk);
    tick; rst_n = 1'b0;
    set_m(1, 1, 0, 14'h020, 32'h0, 4'hF);
    @(negedge clk);
    chk("t6_rst_stb", s_stb, 0);
    chk("t6_rst_ack", m_ack, 0);
    chk("t6_rst_err", m_err, 0);
    @(negedge clk);
    chk("t6_rst_idle_stb", s_stb, 0);
    tick; rst_n = 1'b1; dly = 1;
    push_exp(2'b01, 2'b00, 1, 32'hDEADBEEF, 0);
    wait_resp(10);
    chk("t6_first_owner", m_ack, 2'b01);
    tick; m_stb = 2'b00;

    repeat (3) tick;
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
